hedios_host_master: RTL and testbench
=====================================

Name: hedios_host_master

Overview:
- Host-side initiator for the Hedios serial link. It is the far end that drives command packets into an endpoint and collects its reply.
- Accepts one request (8-bit command + 32-bit data), serializes it as a 5-byte UART frame on tx_line, then optionally waits for a 5-byte response on rx_line, with a timeout.
- Used for board-to-board bridging and as the link master in system-level benches; contains its own bit-level UART TX/RX.

Parameters:
- CLK_RATE, 100_000_000, clock frequency in Hz.
- BAUD_RATE, 1_000_000, line rate in bit/s. DIV = CLK_RATE/BAUD_RATE (integer division) must be >= 4; otherwise elaboration error.
- TIMEOUT_CYCLES, 1_000_000, maximum idle gap in clk cycles while awaiting any response byte; 32-bit counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_command  in  8  command byte.
- req_data  in  32  payload.
- req_expect_resp  in  1  1 = wait for a response packet after sending.
- done  out  1  one-cycle pulse at transaction end.
- rsp_command  out  8  received response command; valid while done=1 and held until the next done.
- rsp_data  out  32  received response data; same validity as rsp_command.
- rsp_timeout  out  1  status for the transaction that pulsed done.
- rsp_frame_err  out  1  status for the transaction that pulsed done.
- busy  out  1  = ~req_ready.
- tx_line  out  1  UART out, idle high.
- rx_line  in  1  UART in, asynchronous to clk.

Behaviour:
- Framing:
  - 8N1, LSB first.
  - Packet order: command, data[31:24], data[23:16], data[15:8], data[7:0].
  - Each bit lasts exactly DIV cycles. No gap between TX bytes.
- Reset (rst=0, async):
  - state=IDLE, tx_line=1, req_ready=1, done=0, rsp_command=0, rsp_data=0, rsp_timeout=0, rsp_frame_err=0, all counters=0.
  - Reset asserted mid-transaction aborts it immediately. No done pulse.
- Handshake:
  - Request is accepted on the cycle where req_valid & req_ready.
  - command, data and expect_resp are captured on that edge. Input changes afterwards are ignored.
  - req_ready drops on the next cycle.
- States:
  - IDLE: tx_line=1. RX bytes are discarded. On accept -> SEND, byte_idx=0.
  - SEND:
    - The start bit appears on tx_line the cycle after accept.
    - After the stop bit of byte_idx=4 completes (50*DIV cycles after accept):
      - expect_resp=1 -> WAIT, timeout counter cleared.
      - expect_resp=0 -> DONE with both flags 0; rsp_* keep their previous values.
  - WAIT:
    - Timeout counter increments each cycle while no start bit is detected.
    - Counter reaching TIMEOUT_CYCLES -> DONE with rsp_timeout=1.
  - RECV:
    - Entered from WAIT when a start bit is detected. Timeout counter cleared at each detected start bit.
    - Collect 5 bytes in packet order.
    - Between bytes, timeout counting applies again. Expiry -> DONE with rsp_timeout=1; partial data is not written to rsp_*.
  - DONE (1 cycle):
    - done=1. Status flags are updated here.
    - rsp_* are updated only on a successful receive.
    - Next cycle -> IDLE (req_ready=1). A new request can be accepted on the first cycle back in IDLE.
- RX bit engine:
  - rx_line passes through a 2-flop synchronizer.
  - Start detect: synchronized falling edge (1 -> 0).
  - Start bit is re-checked at DIV/2 cycles. If high, it is a glitch: ignore and resume waiting, without clearing the timeout.
  - Data bits are sampled every DIV cycles thereafter. The stop bit is sampled at its mid-point.
  - Stop bit sampled 0 -> DONE with rsp_frame_err=1, then IDLE. The next start detect requires rx_line to be seen high first.
- Latency:
  - done follows the mid-stop sample of the 5th response byte by exactly 1 cycle.
  - rsp_timeout and rsp_frame_err are never both 1.
- Simultaneous events:
  - Timeout expiry on the same cycle as a start detect: the start detect wins.
  - req_valid during DONE is not accepted until IDLE.

Test Plan:
- CLK_RATE=100M, BAUD_RATE=10M (DIV=10), TIMEOUT_CYCLES=200 for all scenarios.
- Send without response: cmd=0x21, data=0xDEADBEEF, expect=0 -> tx_line carries bytes 21 DE AD BE EF, 8N1 LSB-first at 10-cycle bits; done pulses 500 cycles after accept; both flags 0.
- Round trip: cmd=0x10, data=0, expect=1; bench returns 0x90,0x12,0x34,0x56,0x78 after a 50-cycle gap -> done with rsp_command=0x90, rsp_data=0x12345678, flags 0; rsp_* held until the next done.
- Timeout: expect=1, no reply -> done exactly 200 cycles after the TX stop bit ends; rsp_timeout=1; rsp_* unchanged. Repeat with 2 reply bytes then silence -> timeout 200 cycles after the last byte's start.
- Frame error and glitch: reply whose 3rd byte has stop=0 -> done with rsp_frame_err=1. A 3-cycle low glitch on rx_line during WAIT -> ignored, no done.
- Reset mid-SEND: drop rst at byte 2 -> tx_line=1 and req_ready=1 immediately, no done; after release, a fresh request transmits correctly.
- Back-to-back: req_valid held high with 3 queued requests -> each accepted on the cycle after the previous done; req_ready low otherwise.

Source files
------------

// File: rtl/hedios_host_master.sv
// hedios_host_master: host-side Hedios link initiator; sends a 5-byte 8N1 command packet
// and optionally collects a 5-byte response with an inter-byte idle timeout.
module hedios_host_master #(
    parameter int CLK_RATE       = 100_000_000,
    parameter int BAUD_RATE      = 1_000_000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_command,
    input  logic [31:0] req_data,
    input  logic        req_expect_resp,
    output logic        done,
    output logic [7:0]  rsp_command,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout,
    output logic        rsp_frame_err,
    output logic        busy,
    output logic        tx_line,
    input  logic        rx_line
);
    localparam int DIV  = CLK_RATE / BAUD_RATE;
    localparam int HALF = DIV / 2;
    localparam int DW   = $clog2(DIV);
    localparam logic [DW-1:0] DIV_M1  = DW'(DIV - 1);
    localparam logic [DW-1:0] HALF_M1 = DW'(HALF - 1);
    localparam logic [31:0]   TMO_M1  = 32'(TIMEOUT_CYCLES - 1);

    if (DIV < 4) begin : g_div_check
        $error("hedios_host_master: CLK_RATE/BAUD_RATE must be at least 4");
    end

    typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, DONE} state_t;
    state_t state, state_next;

    logic [49:0]   tx_sh;
    logic [DW-1:0] tx_div;
    logic [5:0]    tx_bit;
    logic          expect_q;
    logic          rx_s1, rx_s2, rx_prev;
    logic          rx_busy;
    logic [DW-1:0] rx_div;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_sh;
    logic [31:0]   rx_buf;
    logic [2:0]    rx_byte;
    logic [31:0]   tmo;

    logic tx_tick, tx_last, hunting, fall, start_det, expire;
    logic rx_tick, start_ok, glitch, stop_smp, frame_bad, pkt_ok;
    logic [49:0] frame;

    // Whole packet as one LSB-first bit stream: start, 8 data bits, stop per byte.
    assign frame = {1'b1, req_data[7:0], 1'b0, 1'b1, req_data[15:8], 1'b0,
                    1'b1, req_data[23:16], 1'b0, 1'b1, req_data[31:24], 1'b0,
                    1'b1, req_command, 1'b0};

    assign tx_tick   = tx_div == DIV_M1;
    assign tx_last   = tx_tick && tx_bit == 6'd49;
    assign hunting   = (state == WAIT || state == RECV) && !rx_busy;
    assign fall      = rx_prev && !rx_s2;
    assign start_det = hunting && fall;
    assign expire    = hunting && !fall && tmo >= TMO_M1;
    assign rx_tick   = rx_busy && rx_div == '0;
    assign start_ok  = rx_tick && rx_bit == 4'd0 && !rx_s2;
    assign glitch    = rx_tick && rx_bit == 4'd0 && rx_s2;
    assign stop_smp  = rx_tick && rx_bit == 4'd9;
    assign frame_bad = stop_smp && !rx_s2;
    assign pkt_ok    = stop_smp && rx_s2 && rx_byte == 3'd4;

    assign req_ready = state == IDLE;
    assign busy      = ~req_ready;
    assign done      = state == DONE;
    assign tx_line   = tx_sh[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       state_next = req_valid ? SEND : IDLE;
            SEND:       state_next = tx_last ? (expect_q ? WAIT : DONE) : SEND;
            WAIT, RECV: state_next = (expire || frame_bad || pkt_ok) ? DONE : (start_ok ? RECV : state);
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_sh         <= '1;
            tx_div        <= '0;
            tx_bit        <= '0;
            expect_q      <= 1'b0;
            rx_s1         <= 1'b1;
            rx_s2         <= 1'b1;
            rx_prev       <= 1'b1;
            rx_busy       <= 1'b0;
            rx_div        <= '0;
            rx_bit        <= '0;
            rx_sh         <= '0;
            rx_buf        <= '0;
            rx_byte       <= '0;
            tmo           <= '0;
            rsp_command   <= '0;
            rsp_data      <= '0;
            rsp_timeout   <= 1'b0;
            rsp_frame_err <= 1'b0;
        end else begin
            rx_s1   <= rx_line;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            if (state == IDLE && req_valid) begin
                tx_sh    <= frame;
                tx_div   <= '0;
                tx_bit   <= '0;
                expect_q <= req_expect_resp;
            end else if (state == SEND) begin
                tx_div <= tx_tick ? '0 : tx_div + 1'b1;
                if (tx_tick) begin
                    tx_sh  <= {1'b1, tx_sh[49:1]};
                    tx_bit <= tx_bit + 1'b1;
                end
            end
            // A confirmed start reloads the gap counter as if it had been cleared at the edge,
            // so a rejected glitch leaves the running count untouched.
            tmo <= (state == WAIT || state == RECV) ? (start_ok ? 32'(HALF) : tmo + 32'd1) : '0;
            if (state == SEND) rx_byte <= '0;
            if (rx_busy) begin
                rx_div <= rx_tick ? DIV_M1 : rx_div - 1'b1;
                if (rx_tick) begin
                    rx_bit <= rx_bit + 1'b1;
                    if (rx_bit != 4'd0 && rx_bit != 4'd9) rx_sh <= {rx_s2, rx_sh[7:1]};
                    if (glitch || rx_bit == 4'd9) rx_busy <= 1'b0;
                    if (rx_bit == 4'd9 && rx_s2) begin
                        rx_buf  <= {rx_buf[23:0], rx_sh};
                        rx_byte <= rx_byte + 1'b1;
                    end
                end
            end else if (start_det) begin
                rx_busy <= 1'b1;
                rx_div  <= HALF_M1;
                rx_bit  <= '0;
            end
            if (state_next == DONE) begin
                rsp_timeout   <= expire;
                rsp_frame_err <= frame_bad;
                if (pkt_ok) {rsp_command, rsp_data} <= {rx_buf, rx_sh};
            end
        end
    end
endmodule

// File: tb/tb_hedios_host_master.sv
// tb_hedios_host_master: directed and randomized transactions checked against a
// packet-level model of expected TX bytes, response contents and done timing.
module tb_hedios_host_master;
    localparam int DIV = 10;
    localparam int TMO = 200;
    localparam int SYNC = 3;

    logic        clk = 1'b0, rst = 1'b0;
    logic        req_valid = 1'b0, req_expect_resp = 1'b0, rx_line = 1'b1;
    logic [7:0]  req_command = '0;
    logic [31:0] req_data = '0;
    logic        req_ready, done, rsp_timeout, rsp_frame_err, busy, tx_line;
    logic [7:0]  rsp_command;
    logic [31:0] rsp_data;

    hedios_host_master #(.CLK_RATE(100_000_000), .BAUD_RATE(10_000_000), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_command(req_command), .req_data(req_data), .req_expect_resp(req_expect_resp),
        .done(done), .rsp_command(rsp_command), .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout), .rsp_frame_err(rsp_frame_err), .busy(busy),
        .tx_line(tx_line), .rx_line(rx_line)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          done_cnt = 0, done_cyc = 0;
    logic [7:0]  d_cmd = '0;
    logic [31:0] d_data = '0;
    logic        d_tmo = 1'b0, d_ferr = 1'b0;
    always @(negedge clk) begin
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            d_cmd    <= rsp_command;
            d_data   <= rsp_data;
            d_tmo    <= rsp_timeout;
            d_ferr   <= rsp_frame_err;
        end
    end

    int          passed = 0, total = 0, fails = 0;
    logic [7:0]  m_cmd = '0;
    logic [31:0] m_data = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        total++;
        assert (obs === req) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 3000 && !req_ready; i++) @(negedge clk);
        chk("ready_wait", req_ready, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx_line = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx_line = stop;
        repeat (DIV) @(negedge clk);
        rx_line = 1'b1;
    endtask

    // One request; rep holds the reply packet, first byte in [39:32]; bad = index of byte
    // sent with a low stop bit (5 = none); gap = cycles from TX end to the first reply start.
    task automatic transact(input logic [7:0] cmd, input logic [31:0] data, input logic want_resp,
                            input int nrep, input logic [39:0] rep, input int bad,
                            input int gap, input int igap, input logic glitch);
        int a, t, d, n0, want;
        logic [49:0] bits;
        logic [39:0] pkt;
        logic exp_to, exp_fe;
        exp_to = 1'b0;
        exp_fe = 1'b0;
        d = 0;
        pkt = {cmd, data};
        wait_ready();
        chk("rsp_command_held", rsp_command, m_cmd);
        chk("rsp_data_held", rsp_data, m_data);
        req_command = cmd;
        req_data = data;
        req_expect_resp = want_resp;
        req_valid = 1'b1;
        a = cyc + 1;
        n0 = done_cnt;
        @(negedge clk);
        req_valid = 1'b0;
        req_command = 8'($urandom);
        req_data = $urandom;
        req_expect_resp = 1'($urandom);
        chk("ready_drop", req_ready, 1'b0);
        chk("busy_after_accept", busy, 1'b1);
        for (int j = 0; j < 50; j++) begin
            while (cyc < a + DIV * j + DIV / 2) @(negedge clk);
            bits[j] = tx_line;
        end
        for (int k = 0; k < 5; k++) begin
            chk("tx_framing", {bits[10*k+9], bits[10*k]}, 2'b10);
            chk("tx_byte", bits[10*k+1 +: 8], pkt[39-8*k -: 8]);
        end
        t = a + 50 * DIV;
        want = t;
        if (want_resp) begin
            while (cyc < t + gap) @(negedge clk);
            if (glitch) begin
                rx_line = 1'b0;
                repeat (3) @(negedge clk);
                rx_line = 1'b1;
                repeat (20) @(negedge clk);
            end
            for (int k = 0; k < nrep; k++) begin
                d = cyc;
                send_byte(rep[39-8*k -: 8], k != bad);
                if (k == bad) break;
                repeat (igap) @(negedge clk);
            end
            if (bad < nrep) begin
                want = d + SYNC + DIV / 2 + 9 * DIV;
                exp_fe = 1'b1;
            end else if (nrep == 5) begin
                want = d + SYNC + DIV / 2 + 9 * DIV;
                m_cmd = rep[39:32];
                m_data = rep[31:0];
            end else begin
                want = (nrep == 0 ? t : d + SYNC) + TMO;
                exp_to = 1'b1;
            end
        end
        for (int i = 0; i < 3000 && done_cnt == n0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("done_count", done_cnt, n0 + 1);
        chk("done_cycle", done_cyc, want);
        chk("rsp_timeout", d_tmo, exp_to);
        chk("rsp_frame_err", d_ferr, exp_fe);
        chk("rsp_command", d_cmd, m_cmd);
        chk("rsp_data", d_data, m_data);
    endtask

    initial begin
        int a, n0, mode;
        repeat (3) @(negedge clk);
        chk("reset_tx_line", tx_line, 1'b1);
        chk("reset_ready", req_ready, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_rsp", {rsp_command, rsp_data, rsp_timeout, rsp_frame_err}, '0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        transact(8'h21, 32'hDEADBEEF, 1'b0, 0, '0, 5, 1, 0, 1'b0);
        transact(8'h10, 32'h0, 1'b1, 5, 40'h90_12345678, 5, 50, 0, 1'b0);
        transact(8'h33, 32'h0000_0001, 1'b1, 0, '0, 5, 1, 0, 1'b0);
        transact(8'h44, 32'h0000_0002, 1'b1, 2, 40'hAA_BBCCDDEE, 5, 30, 5, 1'b0);
        transact(8'h55, 32'h0000_0003, 1'b1, 5, 40'h01_02030405, 2, 20, 0, 1'b0);
        transact(8'h66, 32'h0000_0004, 1'b1, 0, '0, 5, 40, 0, 1'b1);
        transact(8'h77, 32'hCAFEF00D, 1'b1, 5, 40'hC3_A55A0FF0, 5, 40, 3, 1'b1);

        wait_ready();
        req_command = 8'hA5;
        req_data = 32'h5A5A_5A5A;
        req_expect_resp = 1'b1;
        req_valid = 1'b1;
        a = cyc + 1;
        @(negedge clk);
        req_valid = 1'b0;
        while (cyc < a + 20 * DIV + 3) @(negedge clk);
        n0 = done_cnt;
        rst = 1'b0;
        #1;
        chk("midsend_rst_tx_line", tx_line, 1'b1);
        chk("midsend_rst_ready", req_ready, 1'b1);
        chk("midsend_rst_done", done, 1'b0);
        m_cmd = '0;
        m_data = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (600) @(negedge clk);
        chk("midsend_rst_no_done", done_cnt, n0);
        transact(8'h3C, 32'h0BAD_BEEF, 1'b0, 0, '0, 5, 1, 0, 1'b0);

        n0 = done_cnt;
        req_expect_resp = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_command = 8'($urandom);
            req_data = $urandom;
            for (int w = 0; w < 3000 && !req_ready; w++) @(negedge clk);
            if (i > 0) chk("b2b_accept_cycle", cyc, done_cyc + 1);
            a = cyc + 1;
            @(negedge clk);
            chk("b2b_ready_low", req_ready, 1'b0);
            for (int w = 0; w < 3000 && done_cnt == n0 + i; w++) @(negedge clk);
            chk("b2b_done_cycle", done_cyc, a + 50 * DIV);
        end
        req_valid = 1'b0;

        for (int r = 0; r < 8; r++) begin
            mode = $urandom_range(0, 3);
            transact(8'($urandom), $urandom, mode != 0,
                     mode == 2 ? $urandom_range(0, 4) : 5,
                     {$urandom, 8'($urandom)},
                     mode == 3 ? $urandom_range(0, 4) : 5,
                     $urandom_range(1, 100), $urandom_range(0, 30), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
